// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
// Kept small so decode/execute can import the same encodings.
package mips_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program-counter register and next-PC selection for the fetch stage.
// Priority outside BOOT: redirect > stall > halt hold > sequential PC+4.
module fetch_pc_gen
    import mips_pkg::*;
#(
    parameter int PC_W = mips_pkg::PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  fetch_state_t      state_i,
    input  logic [PC_W-1:0]   pc_init_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              halt_hit_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_plus4_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);

    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_nxt;

    // Wraps naturally modulo 2^PC_W.
    assign pc_plus4_o = pc_p0 + STEP;
    assign pc_o       = pc_p0;

    always_comb begin
        pc_nxt = pc_p0;
        if (state_i == BOOT) begin
            pc_nxt = pc_init_i & ALIGN_MASK;
        end else if (redirect_i) begin
            pc_nxt = redirect_pc_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_nxt = pc_p0;
        end else if (state_i == HALT || halt_hit_i) begin
            pc_nxt = pc_p0;
        end else begin
            pc_nxt = pc_plus4_o;
        end
    end

    // --- PC register (stage 0 boundary) ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= '0;
        end else begin
            pc_p0 <= pc_nxt;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: boot/run/halt control, PC generation and the IF/ID pipeline register.
// The HALT word itself enters IF/ID as a valid instruction; fetch then freezes until a redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                        PC_W      = mips_pkg::PC_W,
    parameter int                        INSTR_W   = mips_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0]        HALT_WORD = mips_pkg::HALT_WORD,
    parameter logic [INSTR_W-1:0]        NOP_WORD  = mips_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_W-1:0]     pc_init,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                redirect_i,
    input  logic [PC_W-1:0]     redirect_pc_i,
    output logic [PC_W-1:0]     imem_addr_o,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    output logic [PC_W-1:0]     program_counter,
    output logic [INSTR_W-1:0]  ifid_instr_o,
    output logic [PC_W-1:0]     ifid_pc_o,
    output logic [PC_W-1:0]     ifid_pc4_o,
    output logic                ifid_valid_o,
    output logic                halted_o
);

    fetch_state_t       state_q;
    fetch_state_t       state_nxt;
    logic               halt_hit;
    logic [PC_W-1:0]    pc_plus4;

    logic [INSTR_W-1:0] instr_p1, instr_nxt;
    logic [PC_W-1:0]    pc_p1, pc_nxt;
    logic [PC_W-1:0]    pc4_p1, pc4_nxt;
    logic               vld_p1, vld_nxt;
    logic               halted_q;

    // Only a clean fetch of the halt word stops the machine; a redirected or squashed one is wrong-path.
    assign halt_hit = (state_q == RUN) && (imem_rdata_i == HALT_WORD)
                      && !redirect_i && !flush_i && !stall_i;

    fetch_pc_gen #(
        .PC_W (PC_W)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_i       (state_q),
        .pc_init_i     (pc_init),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_hit_i    (halt_hit),
        .pc_o          (program_counter),
        .pc_plus4_o    (pc_plus4)
    );

    assign imem_addr_o = program_counter;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_hit)   state_nxt = HALT;
            HALT:    if (redirect_i) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        instr_nxt = instr_p1;
        pc_nxt    = pc_p1;
        pc4_nxt   = pc4_p1;
        vld_nxt   = vld_p1;
        if (state_q == BOOT) begin
            instr_nxt = NOP_WORD;
            vld_nxt   = 1'b0;
        end else if (flush_i || redirect_i) begin
            instr_nxt = NOP_WORD;
            vld_nxt   = 1'b0;
        end else if (stall_i) begin
            instr_nxt = instr_p1;
        end else if (state_q == HALT) begin
            instr_nxt = NOP_WORD;
            vld_nxt   = 1'b0;
        end else begin
            instr_nxt = imem_rdata_i;
            pc_nxt    = program_counter;
            pc4_nxt   = pc_plus4;
            vld_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            halted_q <= (state_nxt == HALT);
        end
    end

    // --- IF/ID register (stage 1 boundary) ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= NOP_WORD;
            pc_p1    <= '0;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            instr_p1 <= instr_nxt;
            pc_p1    <= pc_nxt;
            pc4_p1   <= pc4_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    assign ifid_instr_o = instr_p1;
    assign ifid_pc_o    = pc_p1;
    assign ifid_pc4_o   = pc4_p1;
    assign ifid_valid_o = vld_p1;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle controls with hand-derived PC / IF/ID expectations,
// plus a hand-written async-reset-and-reboot sequence.
module tb_fetch_stage;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;
    localparam logic [31:0] HALT_ADDR = 32'd540;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_init;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] program_counter, ifid_instr_o, ifid_pc_o, ifid_pc4_o;
    logic        ifid_valid_o, halted_o;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_init         (pc_init),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .program_counter (program_counter),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_valid_o    (ifid_valid_o),
        .halted_o        (halted_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return (a == HALT_ADDR) ? HALT_W : (a ^ 32'h2400_0000);
    endfunction

    // Asynchronous instruction memory.
    always_comb imem_rdata_i = instr_at(imem_addr_o);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                                input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] ipc,
                                input logic [31:0] pc4, input logic v, input logic h);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.rpc = rpc;
        t.pc = pc; t.instr = instr; t.ipc = ipc; t.pc4 = pc4; t.valid = v; t.halted = h;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] ipc, input logic [31:0] pc4, input logic v, input logic h);
        check("pc",      idx, program_counter, pc);
        check("imem",    idx, imem_addr_o,     pc);
        check("instr",   idx, ifid_instr_o,    instr);
        check("ifid_pc", idx, ifid_pc_o,       ipc);
        check("pc4",     idx, ifid_pc4_o,      pc4);
        check("valid",   idx, {31'b0, ifid_valid_o}, {31'b0, v});
        check("halted",  idx, {31'b0, halted_o},     {31'b0, h});
    endtask

    initial begin
        rst_n = 1'b0; pc_init = 32'd500;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        //            s  f  r  rpc            pc             instr                 ipc            pc4            v  h
        vecs.push_back(mk(0, 0, 0, 0,            32'd500,       NOP_W,                0,             0,             0, 0)); // BOOT
        vecs.push_back(mk(0, 0, 0, 0,            32'd504,       instr_at(500),        32'd500,       32'd504,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd508,       instr_at(504),        32'd504,       32'd508,       1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            32'd508,       instr_at(504),        32'd504,       32'd508,       1, 0)); // stall
        vecs.push_back(mk(1, 0, 0, 0,            32'd508,       instr_at(504),        32'd504,       32'd508,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd512,       instr_at(508),        32'd508,       32'd512,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd516,       instr_at(512),        32'd512,       32'd516,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd520,       instr_at(516),        32'd516,       32'd520,       1, 0));
        vecs.push_back(mk(0, 0, 1, 32'd603,      32'd600,       NOP_W,                32'd516,       32'd520,       0, 0)); // redirect
        vecs.push_back(mk(0, 0, 0, 0,            32'd604,       instr_at(600),        32'd600,       32'd604,       1, 0));
        vecs.push_back(mk(0, 1, 0, 0,            32'd608,       NOP_W,                32'd600,       32'd604,       0, 0)); // flush
        vecs.push_back(mk(0, 0, 0, 0,            32'd612,       instr_at(608),        32'd608,       32'd612,       1, 0));
        vecs.push_back(mk(1, 1, 0, 0,            32'd612,       NOP_W,                32'd608,       32'd612,       0, 0)); // stall+flush
        vecs.push_back(mk(0, 0, 0, 0,            32'd616,       instr_at(612),        32'd612,       32'd616,       1, 0));
        vecs.push_back(mk(1, 0, 1, 32'd532,      32'd532,       NOP_W,                32'd612,       32'd616,       0, 0)); // stall+redirect
        vecs.push_back(mk(0, 0, 0, 0,            32'd536,       instr_at(532),        32'd532,       32'd536,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd540,       instr_at(536),        32'd536,       32'd540,       1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'd540,       HALT_W,               32'd540,       32'd544,       1, 1)); // halt
        vecs.push_back(mk(0, 0, 0, 0,            32'd540,       NOP_W,                32'd540,       32'd544,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0,            32'd540,       NOP_W,                32'd540,       32'd544,       0, 1));
        vecs.push_back(mk(0, 0, 1, 32'd700,      32'd700,       NOP_W,                32'd540,       32'd544,       0, 0)); // wake
        vecs.push_back(mk(0, 0, 0, 0,            32'd704,       instr_at(700),        32'd700,       32'd704,       1, 0));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, NOP_W,               32'd700,       32'd704,       0, 0)); // wrap
        vecs.push_back(mk(0, 0, 0, 0,            32'h0,         instr_at(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,      1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            32'h4,         instr_at(0),          32'h0,         32'h4,         1, 0));
        vecs.push_back(mk(0, 0, 1, 32'd540,      32'd540,       NOP_W,                32'h0,         32'h4,         0, 0));
        vecs.push_back(mk(0, 1, 0, 0,            32'd544,       NOP_W,                32'h0,         32'h4,         0, 0)); // squashed halt
        vecs.push_back(mk(0, 0, 0, 0,            32'd548,       instr_at(544),        32'd544,       32'd548,       1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 0, NOP_W, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall_i = vecs[i].stall; flush_i = vecs[i].flush;
            redirect_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].pc, vecs[i].instr, vecs[i].ipc, vecs[i].pc4, vecs[i].valid, vecs[i].halted);
        end
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;

        // Async reset between edges must clear everything without waiting for a clock.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all(100, 0, NOP_W, 0, 0, 1'b0, 1'b0);
        pc_init = 32'd803;
        @(negedge clk);
        rst_n = 1'b1;
        // Stall and redirect are ignored on the boot edge.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'd900;
        @(posedge clk);
        #1;
        check_all(101, 32'd800, NOP_W, 0, 0, 1'b0, 1'b0);
        stall_i = 1'b0; redirect_i = 1'b0;
        @(posedge clk);
        #1;
        check_all(102, 32'd804, instr_at(800), 32'd800, 32'd804, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
